index_sampler: RTL
==================

INDEX_SAMPLER -- requirements
Module: index_sampler

Interface
REQ-001 SHALL have parameter IDX_WIDTH, default 7, width of each candidate index popped from the FIFO.
REQ-002 SHALL have parameter LIMIT, default 101, exclusive upper bound on valid indices (LIMIT <= 2**IDX_WIDTH).
REQ-003 SHALL have parameter WEIGHT, default 16, number of distinct indices to collect (1 <= WEIGHT <= LIMIT).
REQ-004 SHALL have port clock, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins a new sampling run.
REQ-007 SHALL have port fifo_empty, input, 1, FIFO has no data.
REQ-008 SHALL have port fifo_dout, input, IDX_WIDTH, FIFO read data, valid one cycle after fifo_rd_en.
REQ-009 SHALL have port fifo_rd_en, output, 1, FIFO pop request.
REQ-010 SHALL have port index_out, output, IDX_WIDTH, most recently accepted index.
REQ-011 SHALL have port index_valid, output, 1, one-cycle strobe that index_out is newly accepted.
REQ-012 SHALL have port bitmap, output, LIMIT, bit i set when index i has been accepted.
REQ-013 SHALL have port busy, output, 1, high in state COLLECT.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when WEIGHT indices have been accepted.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DRAIN; IDLE->COLLECT on start; COLLECT->DRAIN when accepted count reaches WEIGHT; DRAIN->IDLE after one cycle.
REQ-016 SHALL, on start in any state, clear bitmap, accepted count and any in-flight read, and enter COLLECT on the next cycle.
REQ-017 SHALL assert fifo_rd_en combinationally iff state==COLLECT, fifo_empty==0, and accepted count plus in-flight accepts < WEIGHT is not yet known satisfied (i.e. count < WEIGHT).
REQ-018 SHALL register a read-valid flag on each fifo_rd_en and evaluate fifo_dout in the following cycle.
REQ-019 SHALL accept a returned index only when index < LIMIT and bitmap[index]==0; otherwise discard it silently.
REQ-020 SHALL, on accept, set bitmap[index], increment count, drive index_out=index and pulse index_valid in the cycle after evaluation.
REQ-021 SHALL discard any read data returning after count has reached WEIGHT (at most one word), without altering bitmap or count.
REQ-022 SHALL pulse done for exactly one cycle, in DRAIN, with bitmap holding exactly WEIGHT set bits.
REQ-023 SHALL hold bitmap stable from done until the next start or reset.
REQ-024 SHALL stall without state change while fifo_empty==1, with fifo_rd_en low.
REQ-025 SHALL ignore start while reset is high; reset takes priority over start.
REQ-026 SHALL size the count register to CLOG2(WEIGHT)+1 bits with no wrap-around.

Reset
REQ-027 SHALL, on reset, enter IDLE and drive fifo_rd_en=0, index_valid=0, index_out=0, bitmap=0, busy=0, done=0, count=0, read-valid=0.
REQ-028 SHALL abort a run on reset mid-operation, discarding in-flight data; no done pulse is produced.

Configuration
REQ-029 SHALL, when macro INDEX_SAMPLER_STATS_EN is defined, add output reject_count (16 bits, saturating) counting discarded out-of-range and duplicate indices, cleared by start and reset.
REQ-030 SHALL, when INDEX_SAMPLER_STATS_EN is undefined, omit reject_count and its logic entirely; all other behaviour identical.

Verification (LIMIT=101, WEIGHT=4)
REQ-031 SHALL test: start, FIFO supplies 5,5,120,7,100,101,3 back-to-back -> index_valid for 5,7,100,3; done once; bitmap bits {3,5,7,100} only; reject_count=3 with stats enabled.
REQ-032 SHALL test: fifo_empty toggled 1/0 every other cycle during supply of 1,2,3,4 -> fifo_rd_en never high while empty; done after 4 accepts.
REQ-033 SHALL test: supply 10,11,12,13,14 continuously -> exactly 10..13 accepted, 14 popped at most once and discarded, bitmap unaffected by 14.
REQ-034 SHALL test: reset asserted after 2 accepts -> all outputs return to reset values next cycle, no done pulse.
REQ-035 SHALL test: start re-pulsed after 2 accepts (20,21) then supply 20,30,40,50 -> bitmap={20,30,40,50}, done once.

Source files
------------

// File: rtl/index_sampler.sv
// index_sampler
//   Pulls candidate indices from an external FIFO and collects WEIGHT distinct
//   in-range values (index < LIMIT) into a bitmap. Duplicates and out-of-range
//   candidates are dropped silently.
//
//   Ports
//     clock        rising-edge clock
//     reset        synchronous, active-high reset (has priority over start)
//     start        one-cycle pulse that (re)starts a sampling run from any state
//     fifo_empty   FIFO has no data
//     fifo_dout    FIFO read data, valid the cycle after fifo_rd_en
//     fifo_rd_en   FIFO pop request (combinational)
//     index_out    most recently accepted index
//     index_valid  one-cycle strobe: index_out was just accepted
//     bitmap       bit i set once index i has been accepted
//     busy         high while collecting
//     done         one-cycle pulse once WEIGHT indices are held in bitmap
//     reject_count (only with INDEX_SAMPLER_STATS_EN) saturating count of
//                  discarded duplicate / out-of-range candidates
//
//   Build option: define INDEX_SAMPLER_STATS_EN to add reject_count.

module index_sampler #(
    parameter int IDX_WIDTH = 7,
    parameter int LIMIT     = 101,
    parameter int WEIGHT    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 fifo_empty,
    input  logic [IDX_WIDTH-1:0] fifo_dout,
    output logic                 fifo_rd_en,
    output logic [IDX_WIDTH-1:0] index_out,
    output logic                 index_valid,
    output logic [LIMIT-1:0]     bitmap,
    output logic                 busy,
    output logic                 done
`ifdef INDEX_SAMPLER_STATS_EN
    ,
    output logic [15:0]          reject_count
`endif
);

    localparam int CW = $clog2(WEIGHT) + 1;
    localparam logic [CW-1:0]        WEIGHT_C = CW'(WEIGHT);
    // One extra bit so LIMIT == 2**IDX_WIDTH is representable.
    localparam logic [IDX_WIDTH:0]   LIMIT_C  = (IDX_WIDTH + 1)'(LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [LIMIT-1:0]     bitmap_q, bitmap_d;
    logic [IDX_WIDTH-1:0] index_out_q, index_out_d;
    logic                 index_valid_q, index_valid_d;
`ifdef INDEX_SAMPLER_STATS_EN
    logic [15:0]          reject_q, reject_d;
`endif

    logic in_range;
    logic is_new;
    logic evaluate;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bitmap_d      = bitmap_q;
        index_out_d   = index_out_q;
        index_valid_d = 1'b0;
`ifdef INDEX_SAMPLER_STATS_EN
        reject_d      = reject_q;
`endif

        fifo_rd_en = (state_q == COLLECT) && !fifo_empty && (count_q < WEIGHT_C);
        rd_valid_d = fifo_rd_en;

        in_range = ({1'b0, fifo_dout} < LIMIT_C);
        is_new   = in_range && !bitmap_q[fifo_dout];
        // Data returning after the quota is met (at most one word) is ignored.
        evaluate = rd_valid_q && (state_q == COLLECT) && (count_q < WEIGHT_C);

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            COLLECT: begin
                if (evaluate) begin
                    if (is_new) begin
                        bitmap_d[fifo_dout] = 1'b1;
                        count_d             = count_q + CW'(1);
                        index_out_d         = fifo_dout;
                        index_valid_d       = 1'b1;
                        if (count_d == WEIGHT_C) begin
                            state_d = DRAIN;
                        end
                    end
`ifdef INDEX_SAMPLER_STATS_EN
                    else if (reject_q != '1) begin
                        reject_d = reject_q + 16'd1;
                    end
`endif
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start pulse wins over everything in the run and drops any read in flight.
        if (start) begin
            state_d       = COLLECT;
            count_d       = '0;
            rd_valid_d    = 1'b0;
            bitmap_d      = '0;
            index_valid_d = 1'b0;
`ifdef INDEX_SAMPLER_STATS_EN
            reject_d      = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            rd_valid_q    <= 1'b0;
            bitmap_q      <= '0;
            index_out_q   <= '0;
            index_valid_q <= 1'b0;
`ifdef INDEX_SAMPLER_STATS_EN
            reject_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_valid_q    <= rd_valid_d;
            bitmap_q      <= bitmap_d;
            index_out_q   <= index_out_d;
            index_valid_q <= index_valid_d;
`ifdef INDEX_SAMPLER_STATS_EN
            reject_q      <= reject_d;
`endif
        end
    end

    assign index_out   = index_out_q;
    assign index_valid = index_valid_q;
    assign bitmap      = bitmap_q;
    assign busy        = (state_q == COLLECT);
    assign done        = (state_q == DRAIN);
`ifdef INDEX_SAMPLER_STATS_EN
    assign reject_count = reject_q;
`endif

endmodule
